// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: command codes and
// burst controller state encoding.
package usr_pkg;

    // Command codes carried on the 3-bit mode input
    localparam logic [2:0] USR_HOLD = 3'b000;
    localparam logic [2:0] USR_SHR  = 3'b001;
    localparam logic [2:0] USR_SHL  = 3'b010;
    localparam logic [2:0] USR_LOAD = 3'b011;
    localparam logic [2:0] USR_BSHR = 3'b100;
    localparam logic [2:0] USR_BSHL = 3'b101;
    localparam logic [2:0] USR_ROTR = 3'b110;
    localparam logic [2:0] USR_ROTL = 3'b111;

    // Burst controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } usr_state_t;

    // True for the two multi-cycle burst commands
    function automatic logic is_burst(input logic [2:0] code);
        return (code == USR_BSHR) || (code == USR_BSHL);
    endfunction

endpackage

// File: rtl/usr_burst_ctrl.sv
// Burst controller for usr_shift_reg.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no burst running; every command is accepted
// BUSY  | shifting once per edge until the down-counter reaches zero
// DONE  | single-cycle completion pulse; every command is accepted
//
// The counter is loaded with the clamped burst length on the accept edge,
// so the register itself does not move on that edge; the shifts happen on
// the following N edges.
module usr_burst_ctrl
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(WIDTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic [2:0]    mode,
    input  logic [AW-1:0] amt,
    output logic          shift_en,
    output logic          shift_left,
    output logic          cmd_ready,
    output logic          busy,
    output logic          done
);

    localparam logic [AW-1:0] WIDTH_C = AW'(WIDTH);

    usr_state_t    state, state_nxt;
    logic [AW-1:0] cnt, cnt_nxt;
    logic          dir, dir_nxt;
    logic [AW-1:0] amt_clamped;

    // Requests longer than the register are trimmed to a full-width burst
    always_comb begin
        amt_clamped = (amt > WIDTH_C) ? WIDTH_C : amt;
    end

    // State register, counter, latched direction and registered flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            dir   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            dir   <= dir_nxt;
            busy  <= (state_nxt == ST_BUSY);
            done  <= (state_nxt == ST_DONE);
        end
    end

    // Next-state logic: accept bursts outside BUSY, count down inside it
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        dir_nxt   = dir;
        case (state)
            ST_IDLE, ST_DONE: begin
                state_nxt = ST_IDLE;
                if (en && is_burst(mode)) begin
                    dir_nxt = (mode == USR_BSHL);
                    if (amt_clamped == '0) begin
                        state_nxt = ST_DONE;
                    end else begin
                        cnt_nxt   = amt_clamped;
                        state_nxt = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                cnt_nxt = cnt - AW'(1);
                if (cnt == AW'(1)) begin
                    state_nxt = ST_DONE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Datapath handshake derived from the current state
    always_comb begin
        shift_en   = (state == ST_BUSY);
        shift_left = dir;
        cmd_ready  = (state != ST_BUSY);
    end

endmodule

// File: rtl/usr_shift_reg.sv
// Universal shift register: hold, load, single-step shifts and
// multi-cycle burst shifts driven by usr_burst_ctrl.
// Optional build macro USR_ROTATE_EN enables the rotate commands; without
// it the rotate codes act as hold and no rotate datapath exists.
module usr_shift_reg
    import usr_pkg::*;
#(
    parameter int                 WIDTH     = 8,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic [2:0]                   mode,
    input  logic [$clog2(WIDTH+1)-1:0]   amt,
    input  logic [WIDTH-1:0]             d,
    input  logic                         sin_l,
    input  logic                         sin_r,
    output logic [WIDTH-1:0]             q,
    output logic                         sout_l,
    output logic                         sout_r,
    output logic                         busy,
    output logic                         done
);

    localparam int AW = $clog2(WIDTH + 1);

    logic             shift_en;
    logic             shift_left;
    logic             cmd_ready;
    logic [WIDTH-1:0] q_nxt;

    usr_burst_ctrl #(
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_ctrl (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .mode       (mode),
        .amt        (amt),
        .shift_en   (shift_en),
        .shift_left (shift_left),
        .cmd_ready  (cmd_ready),
        .busy       (busy),
        .done       (done)
    );

    // Next register value: burst shifting has priority, commands apply only
    // when the controller is not mid-burst
    always_comb begin
        q_nxt = q;
        if (shift_en) begin
            if (shift_left) begin
                q_nxt = {q[WIDTH-2:0], sin_r};
            end else begin
                q_nxt = {sin_l, q[WIDTH-1:1]};
            end
        end else if (cmd_ready && en) begin
            case (mode)
                USR_SHR:  q_nxt = {sin_l, q[WIDTH-1:1]};
                USR_SHL:  q_nxt = {q[WIDTH-2:0], sin_r};
                USR_LOAD: q_nxt = d;
`ifdef USR_ROTATE_EN
                USR_ROTR: q_nxt = {q[0], q[WIDTH-1:1]};
                USR_ROTL: q_nxt = {q[WIDTH-2:0], q[WIDTH-1]};
`endif
                default:  q_nxt = q;
            endcase
        end
    end

    // Register bank
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= RESET_VAL;
        end else begin
            q <= q_nxt;
        end
    end

    // Serial outputs track the end bits directly
    assign sout_l = q[WIDTH-1];
    assign sout_r = q[0];

endmodule

// File: tb/tb_usr_shift_reg.sv
// Directed testbench for usr_shift_reg (WIDTH = 8, RESET_VAL = 0).
module tb_usr_shift_reg;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [2:0] mode;
    logic [3:0] amt;
    logic [7:0] d;
    logic       sin_l;
    logic       sin_r;
    logic [7:0] q;
    logic       sout_l;
    logic       sout_r;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    usr_shift_reg #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .mode   (mode),
        .amt    (amt),
        .d      (d),
        .sin_l  (sin_l),
        .sin_r  (sin_r),
        .q      (q),
        .sout_l (sout_l),
        .sout_r (sout_r),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] val);
        en = 1'b1; mode = 3'b011; d = val;
        tick();
        en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b0; mode = 3'b000; amt = '0; d = '0;
        sin_l = 1'b0; sin_r = 1'b0;
        #2;
        checks++;
        if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_init q=%h busy=%b done=%b want q=00 busy=0 done=0", q, busy, done);
        end
        tick(); tick();
        reset = 1'b0;
        load(8'hFF);
        checks++;
        if (q !== 8'hFF) begin
            errors++;
            $display("FAIL pre_reset_load q=%h want ff", q);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset q=%h busy=%b done=%b want q=00 busy=0 done=0", q, busy, done);
        end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_load_hold();
        load(8'hA5);
        checks++;
        if (q !== 8'hA5) begin
            errors++;
            $display("FAIL load q=%h want a5", q);
        end
        en = 1'b0; mode = 3'b001; sin_l = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (q !== 8'hA5) begin
                errors++;
                $display("FAIL hold_%0d q=%h want a5", i, q);
            end
        end
    endtask

    task automatic test_single_shift();
        en = 1'b1; mode = 3'b001; sin_l = 1'b1;
        tick();
        en = 1'b0;
        checks++;
        if (q !== 8'hD2 || sout_r !== 1'b0 || sout_l !== 1'b1) begin
            errors++;
            $display("FAIL shr q=%h sout_r=%b sout_l=%b want d2 0 1", q, sout_r, sout_l);
        end
        load(8'hA5);
        en = 1'b1; mode = 3'b010; sin_r = 1'b0;
        tick();
        en = 1'b0;
        checks++;
        if (q !== 8'h4A || sout_l !== 1'b0 || sout_r !== 1'b0) begin
            errors++;
            $display("FAIL shl q=%h sout_l=%b sout_r=%b want 4a 0 0", q, sout_l, sout_r);
        end
    endtask

    task automatic test_burst();
        logic [7:0] exp_q [3] = '{8'h02, 8'h04, 8'h08};
        load(8'h81);
        en = 1'b1; mode = 3'b101; amt = 4'd3; sin_r = 1'b0;
        tick();
        checks++;
        if (q !== 8'h81 || busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL burst_accept q=%h busy=%b done=%b want 81 1 0", q, busy, done);
        end
        // Load command presented while busy must be ignored
        mode = 3'b011; d = 8'h55;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) en = 1'b0;
            tick();
            checks++;
            if (q !== exp_q[i] || busy !== (i < 2) || done !== (i == 2)) begin
                errors++;
                $display("FAIL burst_step_%0d q=%h busy=%b done=%b want %h %b %b",
                         i, q, busy, done, exp_q[i], (i < 2), (i == 2));
            end
        end
        tick();
        checks++;
        if (q !== 8'h08 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL burst_idle q=%h busy=%b done=%b want 08 0 0", q, busy, done);
        end
        en = 1'b1; mode = 3'b100; amt = 4'd0;
        tick();
        en = 1'b0;
        checks++;
        if (q !== 8'h08 || busy !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL burst_zero q=%h busy=%b done=%b want 08 0 1", q, busy, done);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL burst_zero_end done=%b want 0", done);
        end
    endtask

    task automatic test_clamp();
        int n;
        en = 1'b1; mode = 3'b100; amt = 4'd15; sin_l = 1'b1;
        tick();
        en = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            n++;
            tick();
        end
        checks++;
        if (n !== 8 || q !== 8'hFF || done !== 1'b1) begin
            errors++;
            $display("FAIL clamp busy_cycles=%0d q=%h done=%b want 8 ff 1", n, q, done);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        load(8'h01);
        en = 1'b1; mode = 3'b101; amt = 4'd1; sin_r = 1'b0;
        tick();
        tick();
        checks++;
        if (q !== 8'h02 || done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first q=%h done=%b busy=%b want 02 1 0", q, done, busy);
        end
        tick();
        en = 1'b0;
        checks++;
        if (q !== 8'h02 || busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept q=%h busy=%b done=%b want 02 1 0", q, busy, done);
        end
        tick();
        checks++;
        if (q !== 8'h04 || done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second q=%h done=%b want 04 1", q, done);
        end
        tick();
    endtask

    task automatic test_reset_mid_burst();
        int seen;
        load(8'h81);
        en = 1'b1; mode = 3'b101; amt = 4'd8; sin_r = 1'b1;
        tick();
        en = 1'b0;
        tick(); tick();
        checks++;
        if (q !== 8'h07 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_burst q=%h busy=%b want 07 1", q, busy);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort q=%h busy=%b done=%b want 00 0 0", q, busy, done);
        end
        tick();
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0 || q !== 8'h00) begin
            errors++;
            $display("FAIL abort_quiet active_cycles=%0d q=%h want 0 00", seen, q);
        end
    endtask

    task automatic test_rotate();
        logic [7:0] exp_r;
        logic [7:0] exp_l;
`ifdef USR_ROTATE_EN
        exp_r = 8'hC0;
        exp_l = 8'h81;
`else
        exp_r = 8'h81;
        exp_l = 8'h81;
`endif
        load(8'h81);
        en = 1'b1; mode = 3'b110; sin_l = 1'b0; sin_r = 1'b0;
        tick();
        checks++;
        if (q !== exp_r) begin
            errors++;
            $display("FAIL rotr q=%h want %h", q, exp_r);
        end
        mode = 3'b111; sin_r = 1'b0;
        tick();
        en = 1'b0;
        checks++;
        if (q !== exp_l) begin
            errors++;
            $display("FAIL rotl q=%h want %h", q, exp_l);
        end
    endtask

    initial begin
        test_reset();
        test_load_hold();
        test_single_shift();
        test_burst();
        test_clamp();
        test_back_to_back();
        test_reset_mid_burst();
        test_rotate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/usr_shift_reg.md
# usr_shift_reg

Parametrised universal shift register: a WIDTH-bit bank of asynchronously reset flip-flops with hold, parallel load, single-step shifts and multi-cycle burst shifts. It replaces ad-hoc chains of single-bit D flip-flops wherever the design needs serialisation, deserialisation or bit alignment. A small burst controller reports `busy` and `done`, so upstream logic can issue an N-bit shift as one command.

## Interface
Parameters:
- `WIDTH`, default 8: register width; legal range is ≥ 2.
- `RESET_VAL`, default 0: value loaded into `q` on reset.

Ports:
- `clk`  in  1  the single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `en`  in  1  command strobe; a command is sampled only when `en` = 1.
- `mode`  in  3  command code, see Operation.
- `amt`  in  $clog2(WIDTH+1)  burst length in bits.
- `d`  in  WIDTH  parallel load data.
- `sin_l`  in  1  serial input entering at the MSB on right shifts.
- `sin_r`  in  1  serial input entering at the LSB on left shifts.
- `q`  out  WIDTH  register contents.
- `sout_l`  out  1  equals `q[WIDTH-1]`.
- `sout_r`  out  1  equals `q[0]`.
- `busy`  out  1  a burst is in progress.
- `done`  out  1  one-cycle pulse after a burst completes.

## Operation
- Mode codes:
  - 000: hold.
  - 001: shift right, `q <= {sin_l, q[W-1:1]}`.
  - 010: shift left, `q <= {q[W-2:0], sin_r}`.
  - 011: load, `q <= d`.
  - 100: burst right by `amt`.
  - 101: burst left by `amt`.
  - 110: rotate right (see Configuration).
  - 111: rotate left (see Configuration).
- `en` = 0 means hold, regardless of `mode`.
- Controller FSM states are IDLE, BUSY and DONE.
  - In IDLE or DONE, all commands are accepted.
  - On a burst command with `amt` = N > 0: latch N into the counter and go to BUSY. `q` does not change on the accept edge.
  - In BUSY: shift once per edge using the live `sin_l`/`sin_r` and decrement the counter. On the edge where the counter reaches 0, go to DONE.
  - DONE lasts exactly one cycle. The next state is IDLE, or BUSY if a new burst is accepted on that edge.
  - Burst with `amt` = 0: go directly to DONE; `q` is unchanged.
  - `amt` > WIDTH is clamped to WIDTH.
- While BUSY, `en`, `mode`, `amt` and `d` are ignored. Only `reset` has effect.
- `busy` = (state == BUSY). `done` = (state == DONE). Both are registered outputs.

## Timing
- Reset values: `q` = RESET_VAL, state = IDLE, `busy` = 0, `done` = 0, counter = 0.
  - These values take effect immediately on `reset` assertion, with no clock needed.
  - The first command is sampled on the first rising edge after deassertion.
- Single-step modes and load have 1-cycle latency: `q` is valid after the sampling edge.
- `sout_l` and `sout_r` are combinational from `q`, so they have zero additional latency.
- Burst of N, with accept edge E0:
  - `busy` is high from E0 to EN.
  - The shifts occur on edges E1 through EN.
  - `done` is high from EN to EN+1.
  - A new command can be accepted at EN+1.
- Reset asserted mid-burst aborts the burst. No `done` pulse is generated for it.

## Configuration
- `USR_ROTATE_EN`:
  - Defined: modes 110 and 111 rotate; the bit shifted out re-enters at the opposite end, and `sin_l`/`sin_r` are ignored.
  - Undefined: modes 110 and 111 behave as hold, and the rotate datapath is not synthesised.

## Structure
- Package `usr_pkg` contains:
  - the mode code localparams: `USR_HOLD`, `USR_SHR`, `USR_SHL`, `USR_LOAD`, `USR_BSHR`, `USR_BSHL`, `USR_ROTR`, `USR_ROTL`;
  - the FSM state encoding.
- Sub-module `usr_burst_ctrl` contains the FSM, the clamped down-counter and the `busy`/`done` registers. It outputs a shift-enable and a direction to the datapath in `usr_shift_reg`.

## Test plan
All scenarios use WIDTH = 8 and RESET_VAL = 0.
- Async reset: raise `reset` between clock edges while `q` = 0xFF. Required: `q` = 0x00, `busy` = 0 and `done` = 0 before the next edge.
- Load and hold: `en` = 1, `mode` = 011, `d` = 0xA5. Required: `q` = 0xA5 after 1 edge. Then `en` = 0 for 3 edges with `mode` = 001. Required: `q` stays 0xA5.
- Single shifts from 0xA5:
  - Shift right with `sin_l` = 1: `q` = 0xD2, `sout_r` = 0.
  - Reload 0xA5, then shift left with `sin_r` = 0: `q` = 0x4A, `sout_l` = 0.
- Burst: `q` = 0x81, `mode` = 101, `amt` = 3, `sin_r` = 0.
  - Required: `busy` high for 3 cycles; `q` steps through 0x02, 0x04, 0x08.
  - Required: `done` pulses for 1 cycle, then IDLE.
  - Required: a `mode` = 011 command applied while BUSY is ignored.
  - Separately, `amt` = 0 gives a `done` pulse on the next cycle with `q` unchanged.
- Reset mid-burst: `amt` = 8, assert `reset` after 2 shifts. Required: `q` = 0x00, `busy` = 0, and no `done` pulse within the following 10 cycles.
- Rotate: `q` = 0x81, `mode` = 110.
  - With `USR_ROTATE_EN` defined: `q` = 0xC0.
  - Without it: `q` stays 0x81.
